// File: rtl/opcode_sel_sched.sv
// Opcode FIFO + priority-class scheduler granting the shared 2-bit bus for HOLD_A/B/C cycles.
// Grant appears one edge after the pop; op_ready drops only when the FIFO is full (no pass-through).
module opcode_sel_sched #(
   parameter int DEPTH  = 4,
   parameter int HOLD_A = 1,
   parameter int HOLD_B = 2,
   parameter int HOLD_C = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     op_valid,
   output logic                     op_ready,
   input  logic [3:0]               opcode,
   input  logic [1:0]               a,
   input  logic [1:0]               b,
   input  logic [1:0]               c,
   output logic                     out_valid,
   output logic [1:0]               out_data,
   output logic [1:0]               out_sel,
   output logic                     illegal,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   logic [3:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   state_t        r_state;
   logic [3:0]    r_hold;
   logic          r_valid;
   logic [1:0]    r_sel;
   logic [1:0]    r_data;
   logic          r_illegal;

   logic          w_push;
   logic          w_pop;
   logic [3:0]    w_head;
   logic [1:0]    w_new_sel;
   logic [3:0]    w_new_hold;
   logic [1:0]    w_new_data;
   logic [1:0]    w_held_data;

   assign op_ready  = (r_count < L_DEPTH);
   assign w_push    = op_valid && op_ready;
   // The head is consumed whenever the bus is free: idle, or on the last cycle of a grant.
   assign w_pop     = (r_count != '0) && ((r_state == S_IDLE) || (r_hold == 4'd0));
   assign w_head    = r_mem[r_rptr];

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_sel   = r_sel;
   assign illegal   = r_illegal;
   assign count     = r_count;
   assign busy      = (r_state == S_GRANT) || (r_count != '0);

   always_comb begin
      w_new_sel  = 2'b00;
      w_new_hold = 4'd0;
      if (w_head[3]) begin
         w_new_sel  = 2'b01;
         w_new_hold = 4'(HOLD_A - 1);
      end else if (w_head[2]) begin
         w_new_sel  = 2'b10;
         w_new_hold = 4'(HOLD_B - 1);
      end else if (w_head[1]) begin
         w_new_sel  = 2'b11;
         w_new_hold = 4'(HOLD_C - 1);
      end
   end

   always_comb begin
      w_new_data = 2'b00;
      case (w_new_sel)
         2'b01:   w_new_data = a;
         2'b10:   w_new_data = b;
         2'b11:   w_new_data = c;
         default: w_new_data = 2'b00;
      endcase
   end

   always_comb begin
      w_held_data = 2'b00;
      case (r_sel)
         2'b01:   w_held_data = a;
         2'b10:   w_held_data = b;
         2'b11:   w_held_data = c;
         default: w_held_data = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= opcode;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_hold    <= 4'd0;
         r_valid   <= 1'b0;
         r_sel     <= 2'b00;
         r_data    <= 2'b00;
         r_illegal <= 1'b0;
      end else begin
         r_illegal <= 1'b0;
         if ((r_state == S_GRANT) && (r_hold != 4'd0)) begin
            r_hold <= r_hold - 1'b1;
            r_data <= w_held_data;
         end else if (w_pop && (w_new_sel != 2'b00)) begin
            r_state <= S_GRANT;
            r_hold  <= w_new_hold;
            r_valid <= 1'b1;
            r_sel   <= w_new_sel;
            r_data  <= w_new_data;
         end else begin
            r_illegal <= w_pop;
            r_state   <= S_IDLE;
            r_hold    <= 4'd0;
            r_valid   <= 1'b0;
            r_sel     <= 2'b00;
            r_data    <= 2'b00;
         end
      end
   end
endmodule

// File: tb/tb_opcode_sel_sched.sv
// Bench for opcode_sel_sched: scoreboard of expected grants per accepted opcode, checked each cycle,
// plus scenario tasks with inline checks of exact cycle behaviour.
module tb_opcode_sel_sched;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       op_valid = 1'b0;
   logic       op_ready;
   logic [3:0] opcode = 4'd0;
   logic [1:0] a = 2'b00, b = 2'b00, c = 2'b00;
   logic       out_valid;
   logic [1:0] out_data, out_sel;
   logic       illegal, busy;
   logic [2:0] count;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [1:0] sel;
      int         len;
   } exp_t;

   exp_t       sb[$];
   int         rem = 0;
   int         exp_count = 0;
   bit         acc_prev = 1'b0;
   bit         saw_full = 1'b0;
   logic [1:0] cur_sel = 2'b00;
   logic [1:0] pa = 2'b00, pb = 2'b00, pc = 2'b00;

   opcode_sel_sched #(.DEPTH(DEPTH), .HOLD_A(1), .HOLD_B(2), .HOLD_C(3)) dut (
      .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
      .a(a), .b(b), .c(c), .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
      .illegal(illegal), .busy(busy), .count(count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
      $fatal(1, "watchdog");
   end

   function automatic exp_t expect_of(input logic [3:0] op);
      exp_t e;
      if (op >= 4'd8)      begin e.sel = 2'b01; e.len = 1; end
      else if (op >= 4'd4) begin e.sel = 2'b10; e.len = 2; end
      else if (op >= 4'd2) begin e.sel = 2'b11; e.len = 3; end
      else                 begin e.sel = 2'b00; e.len = 0; end
      return e;
   endfunction

   function automatic logic [1:0] operand(input logic [1:0] s);
      case (s)
         2'b01:   return pa;
         2'b10:   return pb;
         2'b11:   return pc;
         default: return 2'b00;
      endcase
   endfunction

   // One clock: scoreboard check of the state left by the previous edge, then advance one edge.
   task automatic tick();
      exp_t e;
      int   popped;
      @(negedge clk);
      popped = 0;
      if (illegal === 1'b1) begin
         n_tests++;
         if (out_valid !== 1'b0 || rem != 0 || sb.size() == 0 || sb[0].sel != 2'b00) begin
            n_fail++;
            $display("FAIL illegal_pulse: out_valid=%b rem=%0d queued=%0d, required illegal head with no grant",
                     out_valid, rem, sb.size());
         end
         if (sb.size() != 0) e = sb.pop_front();
         popped = 1;
      end
      n_tests++;
      if (out_valid === 1'b1) begin
         if (rem == 0) begin
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL grant_extra: out_sel=%b granted, required no grant (scoreboard empty)", out_sel);
            end else begin
               e = sb.pop_front();
               popped  = 1;
               cur_sel = e.sel;
               rem     = e.len;
               if (e.sel == 2'b00) begin
                  n_fail++;
                  $display("FAIL grant_of_illegal: out_sel=%b, required illegal pulse instead", out_sel);
               end
            end
         end
         if (out_sel !== cur_sel || out_data !== operand(cur_sel)) begin
            n_fail++;
            $display("FAIL grant_output: out_sel=%b out_data=%b, required %b/%b",
                     out_sel, out_data, cur_sel, operand(cur_sel));
         end
         if (rem > 0) rem--;
      end else begin
         if (rem != 0 || out_sel !== 2'b00 || out_data !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_output: out_valid=%b out_sel=%b out_data=%b remaining=%0d, required grant/zeros",
                     out_valid, out_sel, out_data, rem);
         end
         rem = 0;
      end
      exp_count = exp_count + (acc_prev ? 1 : 0) - popped;
      n_tests++;
      if (count !== 3'(exp_count) || op_ready !== (exp_count < DEPTH) ||
          busy !== ((out_valid === 1'b1) || (exp_count != 0))) begin
         n_fail++;
         $display("FAIL occupancy: count=%0d op_ready=%b busy=%b, required count=%0d op_ready=%b busy=%b",
                  count, op_ready, busy, exp_count, (exp_count < DEPTH),
                  ((out_valid === 1'b1) || (exp_count != 0)));
      end
      if (count === 3'(DEPTH) && op_ready === 1'b0) saw_full = 1'b1;
      acc_prev = op_valid && (op_ready === 1'b1);
      if (acc_prev) sb.push_back(expect_of(opcode));
      pa = a; pb = b; pc = c;
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] op);
      op_valid = 1'b1;
      opcode   = op;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (acc_prev) begin
            op_valid = 1'b0;
            return;
         end
      end
      op_valid = 1'b0;
      n_tests++;
      n_fail++;
      $display("FAIL push_timeout: opcode %b not accepted in 40 cycles, required acceptance", op);
   endtask

   task automatic drain();
      for (int i = 0; i < 60; i++) begin
         if (sb.size() == 0 && rem == 0 && busy === 1'b0 && exp_count == 0) return;
         tick();
      end
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: busy=%b queued=%0d after 60 cycles, required idle", busy, sb.size());
   endtask

   task automatic do_reset(input string tag);
      rst_n    = 1'b0;
      op_valid = 1'b0;
      #1;
      n_tests++;
      if ({out_valid, out_data, out_sel, illegal, busy} !== 7'b0 || count !== 3'd0 || op_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: valid=%b data=%b sel=%b illegal=%b busy=%b count=%0d op_ready=%b, required all 0, op_ready=1",
                  tag, out_valid, out_data, out_sel, illegal, busy, count, op_ready);
      end
      sb.delete();
      rem = 0; exp_count = 0; acc_prev = 1'b0; cur_sel = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      pa = a; pb = b; pc = c;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #7;
      do_reset("reset_state");
      tick();
   endtask

   task automatic test_single_a();
      a = 2'b11;
      push(4'b1010);
      n_tests++;
      if (out_valid !== 1'b0 || count !== 3'd1) begin
         n_fail++;
         $display("FAIL single_a_accept: out_valid=%b count=%0d, required 0/1", out_valid, count);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'b01 || out_data !== 2'b11) begin
         n_fail++;
         $display("FAIL single_a_grant: valid=%b sel=%b data=%b, required 1/01/11", out_valid, out_sel, out_data);
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_a_end: valid=%b busy=%b, required 0/0", out_valid, busy);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      b = 2'b01; c = 2'b10;
      push(4'b0101);
      push(4'b0010);
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'b10 || out_data !== 2'b01) begin
         n_fail++;
         $display("FAIL b2b_b1: valid=%b sel=%b data=%b, required 1/10/01", out_valid, out_sel, out_data);
      end
      b = 2'b00;
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'b10 || out_data !== 2'b00) begin
         n_fail++;
         $display("FAIL b2b_b2: valid=%b sel=%b data=%b, required 1/10/00", out_valid, out_sel, out_data);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_tests++;
         if (out_valid !== 1'b1 || out_sel !== 2'b11 || out_data !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_c%0d: valid=%b sel=%b data=%b, required 1/11/10", i, out_valid, out_sel, out_data);
         end
      end
      tick();
      n_tests++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: valid=%b, required 0", out_valid);
      end
      drain();
   endtask

   task automatic test_illegal();
      logic [3:0] ills [2] = '{4'b0000, 4'b0001};
      a = 2'b10;
      for (int k = 0; k < 2; k++) begin
         push(ills[k]);
         push(4'b1000);
         n_tests++;
         if (illegal !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_%b_pulse: illegal=%b valid=%b, required 1/0", ills[k], illegal, out_valid);
         end
         tick();
         n_tests++;
         if (illegal !== 1'b0 || out_valid !== 1'b1 || out_sel !== 2'b01 || out_data !== 2'b10) begin
            n_fail++;
            $display("FAIL illegal_%b_then_a: illegal=%b valid=%b sel=%b data=%b, required 0/1/01/10",
                     ills[k], illegal, out_valid, out_sel, out_data);
         end
         tick();
         n_tests++;
         if (illegal !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_%b_end: illegal=%b valid=%b, required 0/0", ills[k], illegal, out_valid);
         end
         drain();
      end
      // illegal entry reached at the end of a grant
      push(4'b0100);
      push(4'b0001);
      push(4'b1100);
      drain();
   endtask

   task automatic test_full_wrap();
      logic [3:0] ops [6] = '{4'b0010, 4'b0011, 4'b0100, 4'b0010, 4'b1111, 4'b0011};
      a = 2'b01; b = 2'b10; c = 2'b11;
      for (int r = 0; r < 3; r++) begin
         saw_full = 1'b0;
         for (int i = 0; i < 6; i++) begin
            push(ops[i]);
            if (i == 2) c = 2'(r);
         end
         drain();
         n_tests++;
         if (saw_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_round%0d: full state seen=%b, required count=4 with op_ready=0", r, saw_full);
         end
      end
   endtask

   task automatic test_reset_mid();
      b = 2'b01;
      push(4'b0100);
      push(4'b1000);
      push(4'b0010);
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'b10 || count !== 3'd2) begin
         n_fail++;
         $display("FAIL mid_setup: valid=%b sel=%b count=%0d, required 1/10/2", out_valid, out_sel, count);
      end
      #2;
      do_reset("reset_mid");
      tick();
      n_tests++;
      if (count !== 3'd0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_after: count=%0d valid=%b, required 0/0", count, out_valid);
      end
      b = 2'b11;
      push(4'b0110);
      tick();
      n_tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'b10 || out_data !== 2'b11) begin
         n_fail++;
         $display("FAIL mid_fresh: valid=%b sel=%b data=%b, required 1/10/11", out_valid, out_sel, out_data);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single_a();
      test_back_to_back();
      test_illegal();
      test_full_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
